mm_bram_responder: RTL and testbench
====================================

# mm_bram_responder

Slave-side responder for the Montgomery multiplier's 32-bit BRAM master port, plus a host streaming port that preloads operands and drains results. It replaces the external Block RAM in simulation and small builds, and sits between the processor-facing logic and the multiplier wrapper. The block holds a single-port word array. The multiplier's BRAM requests always win arbitration over host traffic.

## Interface
- DEPTH, 64: number of 32-bit words; must be a power of two.
- AW, $clog2(DEPTH): word-address width.
- clock_i, input, 1: single clock; all logic is rising-edge.
- reset_n_i, input, 1: asynchronous, active-low reset.
- BRAM_addr_i, input, 32: byte address; word index = BRAM_addr_i[AW+1:2], bits [1:0] ignored.
- BRAM_din_i, input, 32: write data.
- BRAM_we_i, input, 4: per-byte write enables.
- BRAM_en_i, input, 1: access enable.
- BRAM_dout_o, output, 32: registered read data.
- host_cmd_i, input, 1: one-cycle command pulse.
- host_op_i, input, 1: 0 = load, 1 = unload.
- host_base_i, input, AW: first word index.
- host_len_i, input, AW+1: word count, 0..DEPTH.
- load_valid_i, input, 1; load_ready_o, output, 1; load_data_i, input, 32: load stream.
- unload_valid_o, output, 1; unload_ready_i, input, 1; unload_data_o, output, 32: unload stream.
- host_busy_o, output, 1: host command in progress.
- host_done_o, output, 1: one-cycle pulse at command end.
- err_o, output, 1: sticky bounds error.

## Operation
- BRAM port:
  - A cycle with BRAM_en_i=1 and any BRAM_we_i bit set writes the enabled bytes; other bytes are unchanged.
  - Every cycle with BRAM_en_i=1 loads BRAM_dout_o with the old word (read-before-write).
  - BRAM_dout_o holds its value while BRAM_en_i=0.
- Host FSM states: IDLE, LOAD, U_RD, U_OUT, DONE.
- IDLE, on host_cmd_i:
  - Latch base and len, and clear the word counter.
  - len=0 goes to DONE.
  - op=0 goes to LOAD; op=1 goes to U_RD.
  - host_cmd_i outside IDLE is ignored.
- LOAD:
  - load_ready_o = (state==LOAD) && !BRAM_en_i.
  - On each load handshake, write load_data_i to word (base+count) mod DEPTH and increment count.
  - After the len-th word, go to DONE.
- U_RD:
  - If !BRAM_en_i, capture word (base+count) mod DEPTH into a host read register and go to U_OUT.
  - Otherwise stay in U_RD.
- U_OUT:
  - unload_valid_o=1 and unload_data_o = host read register.
  - On handshake, increment count. Go to DONE if count reaches len, otherwise back to U_RD.
- DONE: host_done_o=1 for one cycle, then IDLE.
- host_busy_o=1 in every state except IDLE.
- Host addressing always wraps modulo DEPTH.

## Timing
- Reset values:
  - BRAM_dout_o=0, unload_data_o=0, err_o=0.
  - All valid, ready, busy and done outputs are 0; FSM in IDLE.
  - Array contents are not reset.
- BRAM read latency is 1 cycle: data for an access in cycle n appears on BRAM_dout_o in cycle n+1.
- Load throughput is 1 word/cycle while BRAM_en_i=0.
- Unload throughput is at most 1 word per 2 cycles.
- Command accepted in cycle n with len=0: host_done_o in cycle n+1.
- Simultaneous BRAM_en_i and a host access: the BRAM access proceeds and the host access stalls. No data is lost.
- Reset asserted mid-command aborts it with no done pulse. Words already loaded remain.

## Configuration
- Macro: MM_BRAM_RESP_BOUNDS_CHECK_EN.
- Defined:
  - A BRAM access whose word index (BRAM_addr_i >> 2) is ≥ DEPTH is out of range.
  - Out-of-range writes are dropped; out-of-range reads return 0.
  - err_o sets on the cycle after the access and stays set until reset.
- Undefined:
  - Upper address bits are ignored, so the index wraps modulo DEPTH.
  - err_o is tied to 0.

## Structure
- Shared package mm_bram_pkg holds:
  - the host FSM state enum;
  - the host_op encoding (HOST_LOAD=0, HOST_UNLOAD=1);
  - the BRAM data width constant (32) and the byte-address shift constant (2).
- One sub-module, mm_bram_array: single-port DEPTH×32 storage with byte enables and registered read. The top module contains the arbitration and the FSM.

## Test plan
- BRAM write 0xDEADBEEF at byte addr 0x8 with we=4'hF, then read 0x8 → BRAM_dout_o=0xDEADBEEF one cycle after en.
- Write 0x000000AA at byte addr 0x8 with we=4'b0001 over 0xDEADBEEF → read returns 0xDEADBEAA.
- Host load base=62, len=4, data 1,2,3,4; then BRAM reads of words 62, 63, 0, 1 → 1,2,3,4 (wrap). host_done_o is a single pulse.
- Unload len=3 with BRAM_en_i held high for 5 cycles mid-stream → unload_valid_o stalls, data order is preserved, and BRAM reads stay 1-cycle.
- Command with len=0 → host_done_o the next cycle with no load_ready_o and no unload_valid_o.
- With MM_BRAM_RESP_BOUNDS_CHECK_EN and DEPTH=64, write at byte addr 0x100 → word 0 unchanged, err_o=1 from the next cycle until reset_n_i is low.

Source files
------------

// File: rtl/mm_bram_pkg.sv
// rtl/mm_bram_pkg.sv - shared types and constants for the Montgomery multiplier BRAM responder
package mm_bram_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_SHIFT = 2;

  localparam logic HOST_LOAD   = 1'b0;
  localparam logic HOST_UNLOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_U_RD,
    ST_U_OUT,
    ST_DONE
  } host_state_t;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [3:0]        be
  );
    logic [DATA_W-1:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mm_bram_array.sv
// rtl/mm_bram_array.sv - single-port DEPTH x 32 word store with byte enables and registered read-before-write
module mm_bram_array
  import mm_bram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately left unreset so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en && |we) begin
      mem[addr] <= byte_merge(mem[addr], wdata, we);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mm_bram_responder.sv
// rtl/mm_bram_responder.sv - BRAM slave for the Montgomery multiplier plus host load/unload streaming port
// Optional bounds checking of BRAM addresses: MM_BRAM_RESP_BOUNDS_CHECK_EN.
module mm_bram_responder
  import mm_bram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [31:0]       BRAM_addr_i,
  input  logic [31:0]       BRAM_din_i,
  input  logic [3:0]        BRAM_we_i,
  input  logic              BRAM_en_i,
  output logic [31:0]       BRAM_dout_o,
  input  logic              host_cmd_i,
  input  logic              host_op_i,
  input  logic [AW-1:0]     host_base_i,
  input  logic [AW:0]       host_len_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [31:0]       load_data_i,
  output logic              unload_valid_o,
  input  logic              unload_ready_i,
  output logic [31:0]       unload_data_o,
  output logic              host_busy_o,
  output logic              host_done_o,
  output logic              err_o
);

  host_state_t       state;
  logic [AW-1:0]     base;
  logic [AW:0]       len;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic [AW-1:0]     host_addr;
  logic [AW-1:0]     bram_idx;
  logic              oor;
  logic              host_wr;
  logic              host_rd;
  logic              arr_en;
  logic [3:0]        arr_we;
  logic [AW-1:0]     arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic              bram_fresh;
  logic              bram_oor_q;
  logic [DATA_W-1:0] bram_hold;
  logic              host_fresh;
  logic [DATA_W-1:0] host_hold;
  logic              busy;
  logic              done;
  logic              uvalid;
  logic              unused_addr_bits;

  assign bram_idx   = BRAM_addr_i[AW+ADDR_SHIFT-1:ADDR_SHIFT];
  assign host_addr  = base + count[AW-1:0];
  assign count_next = count + 1'b1;

  assign unused_addr_bits = ^{BRAM_addr_i[DATA_W-1:AW+ADDR_SHIFT], BRAM_addr_i[ADDR_SHIFT-1:0]};

`ifdef MM_BRAM_RESP_BOUNDS_CHECK_EN
  logic err_q;

  assign oor = |BRAM_addr_i[DATA_W-1:AW+ADDR_SHIFT];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_q <= 1'b0;
    end else if (BRAM_en_i && oor) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign oor   = 1'b0;
  assign err_o = 1'b0;
`endif

  // The multiplier's port always owns the array when enabled; host accesses only use idle cycles.
  assign load_ready_o = (state == ST_LOAD) && !BRAM_en_i;
  assign host_wr      = load_ready_o && load_valid_i;
  assign host_rd      = (state == ST_U_RD) && !BRAM_en_i;

  assign arr_en    = BRAM_en_i || host_wr || host_rd;
  assign arr_we    = BRAM_en_i ? (oor ? 4'h0 : BRAM_we_i) : {4{host_wr}};
  assign arr_addr  = BRAM_en_i ? bram_idx : host_addr;
  assign arr_wdata = BRAM_en_i ? BRAM_din_i : load_data_i;

  mm_bram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clock_i),
    .rst_n (reset_n_i),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // The array read register is shared, so each port shows it only in the cycle after
  // its own access and otherwise replays its private copy.
  assign BRAM_dout_o   = bram_fresh ? (bram_oor_q ? '0 : arr_rdata) : bram_hold;
  assign unload_data_o = host_fresh ? arr_rdata : host_hold;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bram_fresh <= 1'b0;
      bram_oor_q <= 1'b0;
      bram_hold  <= '0;
      host_fresh <= 1'b0;
      host_hold  <= '0;
    end else begin
      bram_fresh <= BRAM_en_i;
      bram_oor_q <= BRAM_en_i && oor;
      bram_hold  <= BRAM_dout_o;
      host_fresh <= host_rd;
      host_hold  <= unload_data_o;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= ST_IDLE;
      base   <= '0;
      len    <= '0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      uvalid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host_cmd_i) begin
            base  <= host_base_i;
            len   <= host_len_i;
            count <= '0;
            busy  <= 1'b1;
            if (host_len_i == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (host_op_i == HOST_UNLOAD) begin
              state <= ST_U_RD;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (host_wr) begin
            count <= count_next;
            if (count_next == len) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_U_RD: begin
          if (host_rd) begin
            state  <= ST_U_OUT;
            uvalid <= 1'b1;
          end
        end
        ST_U_OUT: begin
          if (unload_ready_i) begin
            uvalid <= 1'b0;
            count  <= count_next;
            if (count_next == len) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_U_RD;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          uvalid <= 1'b0;
        end
      endcase
    end
  end

  assign host_busy_o    = busy;
  assign host_done_o    = done;
  assign unload_valid_o = uvalid;

endmodule

// File: tb/tb_mm_bram_responder.sv
// tb/tb_mm_bram_responder.sv - scoreboard bench for mm_bram_responder with a word-array reference model
module tb_mm_bram_responder;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   BRAM_addr_i = '0;
  logic [31:0]   BRAM_din_i = '0;
  logic [3:0]    BRAM_we_i = '0;
  logic          BRAM_en_i = 1'b0;
  logic [31:0]   BRAM_dout_o;
  logic          host_cmd_i = 1'b0;
  logic          host_op_i = 1'b0;
  logic [AW-1:0] host_base_i = '0;
  logic [AW:0]   host_len_i = '0;
  logic          load_valid_i = 1'b0;
  logic          load_ready_o;
  logic [31:0]   load_data_i = '0;
  logic          unload_valid_o;
  logic          unload_ready_i = 1'b0;
  logic [31:0]   unload_data_o;
  logic          host_busy_o;
  logic          host_done_o;
  logic          err_o;

  always #5 clk = ~clk;

  mm_bram_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .BRAM_addr_i    (BRAM_addr_i),
    .BRAM_din_i     (BRAM_din_i),
    .BRAM_we_i      (BRAM_we_i),
    .BRAM_en_i      (BRAM_en_i),
    .BRAM_dout_o    (BRAM_dout_o),
    .host_cmd_i     (host_cmd_i),
    .host_op_i      (host_op_i),
    .host_base_i    (host_base_i),
    .host_len_i     (host_len_i),
    .load_valid_i   (load_valid_i),
    .load_ready_o   (load_ready_o),
    .load_data_i    (load_data_i),
    .unload_valid_o (unload_valid_o),
    .unload_ready_i (unload_ready_i),
    .unload_data_o  (unload_data_o),
    .host_busy_o    (host_busy_o),
    .host_done_o    (host_done_o),
    .err_o          (err_o)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_bram [$];
  logic [31:0] exp_unload [$];
  bit          exp_err = 1'b0;
  bit          bram_pend = 1'b0;
  bit          prev_done = 1'b0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      bram_pend = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bram_pend) begin
        chk("bram_expect_available", 32'(exp_bram.size() != 0), 32'd1);
        if (exp_bram.size() != 0) chk("bram_dout", BRAM_dout_o, exp_bram.pop_front());
      end
      bram_pend = BRAM_en_i;
      if (unload_valid_o && unload_ready_i) begin
        chk("unload_expect_available", 32'(exp_unload.size() != 0), 32'd1);
        if (exp_unload.size() != 0) chk("unload_data", unload_data_o, exp_unload.pop_front());
      end
      if (host_done_o) begin
        done_cnt++;
        chk("done_single_pulse", 32'(prev_done), 32'd0);
      end
      prev_done = host_done_o;
    end
  end

  function automatic bit is_oor(input logic [31:0] a);
`ifdef MM_BRAM_RESP_BOUNDS_CHECK_EN
    return (a >> 2) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit in_win(input int idx, input int base, input int len);
    return ((idx - base + DEPTH) % DEPTH) < len;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bram_cycle(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] din);
    int idx;
    tick();
    BRAM_en_i = en; BRAM_we_i = we; BRAM_addr_i = addr; BRAM_din_i = din;
    if (en) begin
      idx = int'((addr >> 2) % DEPTH);
      if (is_oor(addr)) begin
        exp_bram.push_back(32'h0);
        exp_err = 1'b1;
      end else begin
        exp_bram.push_back(ref_mem[idx]);
        for (int b = 0; b < 4; b++) if (we[b]) ref_mem[idx][8*b +: 8] = din[8*b +: 8];
      end
    end
  endtask

  task automatic flush_bram();
    bram_cycle(1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic bram_random(input int n, input int base, input int len, input int pct, input bit writes);
    int idx;
    for (int i = 0; i < n; i++) begin
      do idx = $urandom_range(0, DEPTH-1); while (in_win(idx, base, len));
      bram_cycle(($urandom_range(0, 99) < pct),
                 (writes && $urandom_range(0, 1)) ? 4'($urandom_range(0, 15)) : 4'h0,
                 32'(idx * 4), $urandom);
    end
    bram_cycle(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic host_issue(input logic op, input int base, input int len);
    tick();
    host_cmd_i = 1'b1; host_op_i = op; host_base_i = AW'(base); host_len_i = (AW+1)'(len);
    tick();
    host_cmd_i = 1'b0;
  endtask

  task automatic host_load(input int base, input int len, input bit seq);
    logic [31:0] d;
    int g;
    host_issue(1'b0, base, len);
    for (int i = 0; i < len; i++) begin
      d = seq ? 32'(i + 1) : $urandom;
      ref_mem[(base + i) % DEPTH] = d;
      if ($urandom_range(0, 3) == 0) begin
        load_valid_i = 1'b0;
        tick();
      end
      load_valid_i = 1'b1; load_data_i = d;
      g = 0;
      do begin @(negedge clk); g++; end while (!load_ready_o && g < 2000);
      chk("load_ready_within_budget", 32'(load_ready_o), 32'd1);
      tick();
    end
    load_valid_i = 1'b0;
  endtask

  task automatic host_unload(input int base, input int len);
    int g = 0;
    for (int i = 0; i < len; i++) exp_unload.push_back(ref_mem[(base + i) % DEPTH]);
    host_issue(1'b1, base, len);
    do begin
      tick();
      unload_ready_i = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      g++;
    end while (host_busy_o && g < 2000);
    unload_ready_i = 1'b0;
    chk("unload_queue_drained", 32'(exp_unload.size()), 32'd0);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (host_busy_o && g < 2000) begin @(negedge clk); g++; end
    chk("idle_within_budget", 32'(host_busy_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, len, d0;
    bit op;
    logic [31:0] d;

    repeat (3) @(negedge clk);
    chk("rst_bram_dout", BRAM_dout_o, 32'h0);
    chk("rst_unload_data", unload_data_o, 32'h0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_load_ready", 32'(load_ready_o), 32'd0);
    chk("rst_unload_valid", 32'(unload_valid_o), 32'd0);
    chk("rst_busy", 32'(host_busy_o), 32'd0);
    chk("rst_done", 32'(host_done_o), 32'd0);
    tick();
    rst_n = 1'b1;

    // Fill every word (len = DEPTH) so the model knows the whole array.
    d0 = done_cnt;
    host_load($urandom_range(0, DEPTH-1), DEPTH, 1'b0);
    wait_idle();
    chk("fill_done_count", 32'(done_cnt - d0), 32'd1);

    bram_cycle(1'b1, 4'hF, 32'h8, 32'hDEADBEEF);
    bram_cycle(1'b1, 4'h0, 32'h8, 32'h0);
    bram_cycle(1'b1, 4'b0001, 32'h8, 32'h000000AA);
    bram_cycle(1'b1, 4'h0, 32'h8, 32'h0);
    flush_bram();
    chk("byte_merge_model", ref_mem[2], 32'hDEADBEAA);
    @(negedge clk);
    chk("dout_hold", BRAM_dout_o, 32'hDEADBEAA);

    d0 = done_cnt;
    host_load(62, 4, 1'b1);
    wait_idle();
    chk("wrap_done_count", 32'(done_cnt - d0), 32'd1);
    bram_cycle(1'b1, 4'h0, 32'd248, 32'h0);
    bram_cycle(1'b1, 4'h0, 32'd252, 32'h0);
    bram_cycle(1'b1, 4'h0, 32'd0, 32'h0);
    bram_cycle(1'b1, 4'h0, 32'd4, 32'h0);
    flush_bram();

    // Unload with the multiplier port holding the array for five cycles mid-stream.
    d0 = done_cnt;
    fork
      host_unload(10, 3);
      begin
        repeat (2) tick();
        for (int i = 0; i < 5; i++) bram_cycle(1'b1, 4'h0, 32'((20 + i) * 4), 32'h0);
        bram_cycle(1'b0, 4'h0, 32'h0, 32'h0);
      end
    join
    wait_idle();
    chk("stall_unload_done_count", 32'(done_cnt - d0), 32'd1);

    for (int r = 0; r < 20; r++) begin
      base = $urandom_range(0, DEPTH-1);
      len  = $urandom_range(1, 32);
      op   = $urandom_range(0, 1);
      d0   = done_cnt;
      fork
        begin
          if (op) host_unload(base, len);
          else    host_load(base, len, 1'b0);
        end
        bram_random(2 * len + 4, base, len, 40, 1'b1);
      join
      wait_idle();
      chk("random_done_count", 32'(done_cnt - d0), 32'd1);
    end
    bram_random(40, 0, 0, 70, 1'b1);
    flush_bram();

    d0 = done_cnt;
    tick();
    host_cmd_i = 1'b1; host_op_i = $urandom_range(0, 1); host_base_i = AW'($urandom); host_len_i = '0;
    @(negedge clk);
    chk("len0_no_early_done", 32'(host_done_o), 32'd0);
    tick();
    host_cmd_i = 1'b0;
    @(negedge clk);
    chk("len0_done", 32'(host_done_o), 32'd1);
    chk("len0_no_load_ready", 32'(load_ready_o), 32'd0);
    chk("len0_no_unload_valid", 32'(unload_valid_o), 32'd0);
    @(negedge clk);
    chk("len0_done_cleared", 32'(host_done_o), 32'd0);
    chk("len0_idle", 32'(host_busy_o), 32'd0);
    chk("len0_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset part-way through a load: three words land, the rest of the window is untouched.
    d0 = done_cnt;
    host_issue(1'b0, 40, 8);
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      load_valid_i = 1'b1; load_data_i = d;
      @(negedge clk);
      chk("abort_load_ready", 32'(load_ready_o), 32'd1);
      ref_mem[40 + i] = d;
      tick();
    end
    load_valid_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy_cleared", 32'(host_busy_o), 32'd0);
    chk("abort_load_ready_cleared", 32'(load_ready_o), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    for (int i = 40; i < 44; i++) bram_cycle(1'b1, 4'h0, 32'(i * 4), 32'h0);
    flush_bram();

    bram_cycle(1'b1, 4'hF, 32'h100, 32'h12345678);
    flush_bram();
    chk("err_after_oor", 32'(err_o), 32'(exp_err));
    bram_cycle(1'b1, 4'h0, 32'h0, 32'h0);
    bram_cycle(1'b1, 4'h0, 32'h104, 32'h0);
    flush_bram();
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err_o), 32'(exp_err));
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_reset", 32'(err_o), 32'd0);
    tick();
    rst_n = 1'b1;

    chk("bram_queue_drained", 32'(exp_bram.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
